// File: rtl/dffre_bank_arbiter.sv
// Round-robin write arbiter owning a shared bank of enable/reset registers.
// Latency: request-to-grant 1 cycle, write-to-ack 1 cycle, read 1 cycle.
// Backpressure: only the owner writes; others wait for their grant; i_Enable=0 freezes everything.
//
// Ports:
//   clk, i_Reset (synchronous, active-low), i_Enable (global freeze when low)
//   i_Req/i_Last/i_Addr/i_D : per-requester write stream, requester k at slice k
//   i_RdAddr/o_RdData       : registered read port (old data on same-edge write)
//   o_Grant/o_Ack/o_Busy    : registered ownership, per-write ack pulse, owner-present flag
module dffre_bank_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic [N_REQ-1:0]          i_Req,
  input  logic [N_REQ-1:0]          i_Last,
  input  logic [N_REQ*ADDR_W-1:0]   i_Addr,
  input  logic [N_REQ*WIDTH-1:0]    i_D,
  input  logic [ADDR_W-1:0]         i_RdAddr,
  output logic [N_REQ-1:0]          o_Grant,
  output logic [N_REQ-1:0]          o_Ack,
  output logic                      o_Busy,
  output logic [WIDTH-1:0]          o_RdData
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  dat;
  } wr_cmd_t;

  logic [0:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] bank [DEPTH];

  // First set request at or after the rotating pointer, with wraparound.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] res;
    logic [PTR_W-1:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(p) + i) % N_REQ);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] k);
    return {{(N_REQ-1){1'b0}}, 1'b1} << k;
  endfunction

  logic [PTR_W:0]   pick;
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic             own_req;
  logic             own_last;
  wr_cmd_t          wr_cmd;
  logic             commit;
  logic             release_own;
  logic [DEPTH-1:0] wr_en;

  always_comb begin
    pick     = rr_pick(i_Req, ptr);
    pick_vld = pick[PTR_W];
    pick_idx = pick[PTR_W-1:0];
  end

  always_comb begin
    own_req     = i_Req[owner];
    own_last    = i_Last[owner];
    wr_cmd.addr = i_Addr[int'(owner)*ADDR_W +: ADDR_W];
    wr_cmd.dat  = i_D[int'(owner)*WIDTH +: WIDTH];
    commit      = (state == S_OWN) && own_req && i_Enable && i_Reset;
    // Dropping the request counts as an implicit end of burst.
    release_own = (state == S_OWN) && (!own_req || own_last || (count == CNT_LAST));
  end

  always_comb begin
    wr_en = '0;
    if (commit) wr_en[wr_cmd.addr] = 1'b1;
  end

  // One enable/reset register per bank entry.
  for (genvar j = 0; j < DEPTH; j++) begin : g_bank
    always_ff @(posedge clk) begin
      if (!i_Reset)      bank[j] <= '0;
      else if (wr_en[j]) bank[j] <= wr_cmd.dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_Reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      count    <= '0;
      o_Grant  <= '0;
      o_Ack    <= '0;
      o_Busy   <= 1'b0;
      o_RdData <= '0;
    end else if (!i_Enable) begin
      o_Ack <= '0;
    end else begin
      o_Ack    <= '0;
      o_RdData <= bank[i_RdAddr];
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            state   <= S_OWN;
            owner   <= pick_idx;
            count   <= '0;
            o_Grant <= onehot(pick_idx);
            o_Busy  <= 1'b1;
          end
        end
        S_OWN: begin
          if (own_req) begin
            o_Ack <= onehot(owner);
            count <= count + 1'b1;
          end
          if (release_own) begin
            state   <= S_IDLE;
            o_Grant <= '0;
            o_Busy  <= 1'b0;
            ptr     <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffre_bank_arbiter.sv
// Bench for dffre_bank_arbiter: directed scenarios plus randomized traffic.
// Outputs compared every cycle at negedge against a transaction-level model.
// Inputs change only at negedge.
module tb_dffre_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int MB = 4;
  localparam int AB = N * AW;
  localparam int DB = N * W;

  logic          clk = 1'b0;
  logic          i_Reset;
  logic          i_Enable;
  logic [N-1:0]  i_Req;
  logic [N-1:0]  i_Last;
  logic [AB-1:0] i_Addr;
  logic [DB-1:0] i_D;
  logic [AW-1:0] i_RdAddr;
  logic [N-1:0]  o_Grant;
  logic [N-1:0]  o_Ack;
  logic          o_Busy;
  logic [W-1:0]  o_RdData;

  dffre_bank_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk(clk), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Req(i_Req),
    .i_Last(i_Last), .i_Addr(i_Addr), .i_D(i_D), .i_RdAddr(i_RdAddr),
    .o_Grant(o_Grant), .o_Ack(o_Ack), .o_Busy(o_Busy), .o_RdData(o_RdData)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is a requester number (-1 when nobody owns the bank); writes counts
  // commits since the grant.
  bit          m_valid = 1'b0;
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_writes = 0;
  logic [N-1:0] m_ack = '0;
  logic [W-1:0] m_rd  = '0;
  logic [W-1:0] m_bank [D];

  always @(posedge clk) begin
    if (!i_Reset) begin
      m_valid = 1'b1;
      m_owner = -1;
      m_ptr   = 0;
      m_ack   = '0;
      m_rd    = '0;
      foreach (m_bank[a]) m_bank[a] = '0;
    end else if (!i_Enable) begin
      m_ack = '0;
    end else begin
      m_ack = '0;
      m_rd  = m_bank[i_RdAddr];
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) begin
          if (i_Req[(m_ptr + i) % N]) begin
            m_owner  = (m_ptr + i) % N;
            m_writes = 0;
            break;
          end
        end
      end else if (i_Req[m_owner]) begin
        m_bank[i_Addr[m_owner*AW +: AW]] = i_D[m_owner*W +: W];
        m_ack[m_owner] = 1'b1;
        m_writes++;
        if (i_Last[m_owner] || m_writes == MB) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (m_valid) begin
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("model_grant", 32'(o_Grant), 32'(eg));
      chk("model_ack", 32'(o_Ack), 32'(m_ack));
      chk("model_busy", 32'(o_Busy), 32'(m_owner >= 0));
      chk("model_rddata", 32'(o_RdData), 32'(m_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_wr(input int k, input int a, input int d, input bit last);
    i_Addr[k*AW +: AW] = AW'(a);
    i_D[k*W +: W]      = W'(d);
    i_Last[k]          = last;
  endtask

  task automatic do_reset(input int cycles);
    i_Reset = 1'b0;
    repeat (cycles) step();
    i_Reset = 1'b1;
  endtask

  initial begin
    int acks;
    logic [N-1:0] eg;
    logic [N-1:0] ea;

    i_Reset = 1'b0; i_Enable = 1'b1; i_Req = '1; i_Last = '0;
    i_Addr = '0; i_D = '0; i_RdAddr = '0;

    // Reset held with every request high.
    repeat (3) step();
    chk("rst_grant", 32'(o_Grant), 32'h0);
    chk("rst_ack", 32'(o_Ack), 32'h0);
    chk("rst_busy", 32'(o_Busy), 32'h0);
    chk("rst_rddata", 32'(o_RdData), 32'h0);
    i_Reset = 1'b1; i_Req = '0;
    for (int a = 0; a < D; a++) begin
      i_RdAddr = AW'(a);
      step();
      chk("rst_bank_read", 32'(o_RdData), 32'h0);
    end

    // Single 3-write burst from requester 1.
    i_Req = 4'b0010;
    set_wr(1, 0, 8'hA1, 1'b0);
    step();
    chk("single_grant", 32'(o_Grant), 32'h2);
    acks = 0;
    for (int w = 0; w < 3; w++) begin
      set_wr(1, w, 8'hA1 + w, w == 2);
      step();
      acks += int'(o_Ack[1]);
    end
    i_Req = '0; i_Last = '0;
    chk("single_ack_count", 32'(acks), 32'd3);
    chk("single_released", 32'(o_Grant), 32'h0);
    chk("single_busy_low", 32'(o_Busy), 32'h0);
    step();
    for (int a = 0; a < 3; a++) begin
      i_RdAddr = AW'(a);
      step();
      chk("single_read", 32'(o_RdData), 32'(8'hA1 + a));
    end

    // Fairness: everybody requests forever, no i_Last.
    do_reset(2);
    i_Req = '1; i_Last = '0;
    for (int i = 0; i < 25; i++) begin
      i_Addr = AB'($urandom); i_D = DB'($urandom);
      step();
      eg = ((i % 5) < 4) ? (N'(1) << ((i / 5) % 4)) : '0;
      ea = ((i % 5) >= 1) ? (N'(1) << ((i / 5) % 4)) : '0;
      chk("fair_grant", 32'(o_Grant), 32'(eg));
      chk("fair_ack", 32'(o_Ack), 32'(ea));
    end
    i_Req = '0;
    step();

    // Enable freeze after the first write of a burst.
    do_reset(1);
    i_Req = 4'b0100;
    set_wr(2, 4, 8'h11, 1'b0);
    step();
    step();
    chk("freeze_first_ack", 32'(o_Ack), 32'h4);
    i_Enable = 1'b0;
    set_wr(2, 4, 8'hEE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("freeze_ack", 32'(o_Ack), 32'h0);
      chk("freeze_grant", 32'(o_Grant), 32'h4);
    end
    i_Enable = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      set_wr(2, 5 + (i % 3), 8'h20 + i, 1'b0);
      step();
      acks += int'(o_Ack[2]);
      if (o_Grant == '0) break;
    end
    chk("freeze_remaining_acks", 32'(acks), 32'd3);
    i_Req = '0;
    step();

    // Reset on the second write of a burst.
    do_reset(1);
    i_Req = 4'b0001;
    set_wr(0, 5, 8'h77, 1'b0);
    step();
    step();
    set_wr(0, 6, 8'h88, 1'b0);
    i_Reset = 1'b0;
    step();
    chk("midrst_grant", 32'(o_Grant), 32'h0);
    chk("midrst_busy", 32'(o_Busy), 32'h0);
    i_Reset = 1'b1;
    i_Req = 4'b0100;
    set_wr(2, 3, 8'h11, 1'b0);
    i_RdAddr = 3'd3;
    step();
    chk("midrst_next_grant", 32'(o_Grant), 32'h4);

    // Read/write collision on address 3.
    step();
    set_wr(2, 3, 8'h5C, 1'b1);
    step();
    chk("collide_old", 32'(o_RdData), 32'h11);
    i_Req = '0; i_Last = '0;
    step();
    chk("collide_new", 32'(o_RdData), 32'h5C);
    i_RdAddr = 3'd5;
    step();
    chk("midrst_addr5", 32'(o_RdData), 32'h0);
    i_RdAddr = 3'd6;
    step();
    chk("midrst_addr6", 32'(o_RdData), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      i_Reset  = ($urandom_range(0, 99) != 0);
      i_Enable = ($urandom_range(0, 9) != 0);
      i_Req    = N'($urandom | $urandom);
      for (int k = 0; k < N; k++) i_Last[k] = ($urandom_range(0, 3) == 0);
      i_Addr   = AB'($urandom);
      i_D      = DB'($urandom);
      i_RdAddr = AW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
